// File: rtl/spram_port_ctrl_pkg.sv
// rtl/spram_port_ctrl_pkg.sv - state encodings shared by the spram port controller
package spram_port_ctrl_pkg;

  localparam logic [2:0] ST_CLEAR     = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_DUMP      = 3'd3;
  localparam logic [2:0] ST_DUMP_TAIL = 3'd4;

  typedef enum logic [2:0] {
    CLEAR     = ST_CLEAR,
    IDLE      = ST_IDLE,
    LOAD      = ST_LOAD,
    DUMP      = ST_DUMP,
    DUMP_TAIL = ST_DUMP_TAIL
  } state_t;

endpackage

// File: rtl/spram_port_ctrl_if.sv
// rtl/spram_port_ctrl_if.sv - CPU bus, load stream and dump stream of the port controller
interface spram_port_ctrl_if #(
  parameter int data_width    = 8,
  parameter int address_width = 8
);

  logic [address_width-1:0] cpu_address;
  logic [data_width-1:0]    cpu_data;
  logic                     cpu_wren;
  logic [data_width-1:0]    cpu_q;
  logic                     load_start;
  logic [data_width-1:0]    load_data;
  logic                     load_valid;
  logic                     load_ready;
  logic                     dump_start;
  logic [data_width-1:0]    dump_data;
  logic                     dump_valid;
  logic                     dump_last;
  logic                     busy;

  // controller side
  modport slave (
    input  cpu_address, cpu_data, cpu_wren, load_start, load_data, load_valid, dump_start,
    output cpu_q, load_ready, dump_data, dump_valid, dump_last, busy
  );

  // CPU / host side
  modport master (
    output cpu_address, cpu_data, cpu_wren, load_start, load_data, load_valid, dump_start,
    input  cpu_q, load_ready, dump_data, dump_valid, dump_last, busy
  );

endinterface

// File: rtl/spram.sv
// rtl/spram.sv - single-port RAM with registered q and write-through on write
module spram #(
  parameter int data_width    = 8,
  parameter int address_width = 8
) (
  input  logic                     clk,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    data,
  input  logic                     wren,
  output logic [data_width-1:0]    q
);

  logic [data_width-1:0] mem [0:(2**address_width)-1];

  // synchronous write, registered read; a write returns the written word on q
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[address] <= data;
      q            <= data;
    end else begin
      q <= mem[address];
    end
  end

endmodule

// File: rtl/spram_port_ctrl.sv
// rtl/spram_port_ctrl.sv - time-shares one spram port between CPU and clear/load/dump sequencer
module spram_port_ctrl
  import spram_port_ctrl_pkg::*;
#(
  parameter int                    data_width    = 8,
  parameter int                    address_width = 8,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  spram_port_ctrl_if.slave         bus,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q
);

  localparam logic [address_width-1:0] last_addr = '1;
  localparam logic [address_width-1:0] ctr_one   = {{(address_width-1){1'b0}}, 1'b1};

  state_t                   state;
  logic [address_width-1:0] ctr;
  logic                     load_ready_r;
  logic                     dump_valid_r;
  logic                     dump_last_r;
  logic                     busy_r;

  // q is registered in the RAM, so both read paths are plain passthroughs
  assign bus.cpu_q      = ram_q;
  assign bus.dump_data  = ram_q;
  assign bus.load_ready = load_ready_r;
  assign bus.dump_valid = dump_valid_r;
  assign bus.dump_last  = dump_last_r;
  assign bus.busy       = busy_r;

  // RAM port mux: CPU owns the port only in IDLE, otherwise the sequencer drives ctr
  always_comb begin
    ram_address = ctr;
    ram_data    = clear_value;
    ram_wren    = 1'b0;
    case (state)
      CLEAR: begin
        ram_wren = 1'b1;
      end
      IDLE: begin
        ram_address = bus.cpu_address;
        ram_data    = bus.cpu_data;
        ram_wren    = bus.cpu_wren;
      end
      LOAD: begin
        ram_data = bus.load_data;
        ram_wren = bus.load_valid;
      end
      default: begin
        ram_wren = 1'b0;
      end
    endcase
  end

  // sequencer FSM with registered handshake and busy outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CLEAR;
      ctr          <= '0;
      load_ready_r <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_last_r  <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (ctr == last_addr) begin
            ctr    <= '0;
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            ctr <= ctr + ctr_one;
          end
        end
        IDLE: begin
          // load has priority when both starts arrive together
          if (bus.load_start) begin
            state        <= LOAD;
            load_ready_r <= 1'b1;
            busy_r       <= 1'b1;
          end else if (bus.dump_start) begin
            state  <= DUMP;
            busy_r <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            if (ctr == last_addr) begin
              ctr          <= '0;
              state        <= IDLE;
              load_ready_r <= 1'b0;
              busy_r       <= 1'b0;
            end else begin
              ctr <= ctr + ctr_one;
            end
          end
        end
        DUMP: begin
          // the word addressed this cycle appears on q next cycle
          dump_valid_r <= 1'b1;
          if (ctr == last_addr) begin
            ctr         <= '0;
            state       <= DUMP_TAIL;
            dump_last_r <= 1'b1;
          end else begin
            ctr <= ctr + ctr_one;
          end
        end
        DUMP_TAIL: begin
          dump_valid_r <= 1'b0;
          dump_last_r  <= 1'b0;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state        <= CLEAR;
          ctr          <= '0;
          load_ready_r <= 1'b0;
          dump_valid_r <= 1'b0;
          dump_last_r  <= 1'b0;
          busy_r       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spram_port_ctrl.sv
// tb/tb_spram_port_ctrl.sv - directed self-checking bench for spram_port_ctrl with spram
module tb_spram_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  spram_port_ctrl_if #(.data_width(8), .address_width(8)) bus();

  logic [7:0] ctl_addr, ctl_data, ram_q;
  logic       ctl_wren;
  logic       preload;
  logic [7:0] pre_addr, pre_data;
  logic [7:0] m_addr, m_data;
  logic       m_wren;

  // bench-side preload path lets the RAM hold junk before the controller clears it
  assign m_addr = preload ? pre_addr : ctl_addr;
  assign m_data = preload ? pre_data : ctl_data;
  assign m_wren = preload ? 1'b1     : ctl_wren;

  spram_port_ctrl #(.data_width(8), .address_width(8), .clear_value(8'h00)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .ram_address (ctl_addr),
    .ram_data    (ctl_data),
    .ram_wren    (ctl_wren),
    .ram_q       (ram_q)
  );

  spram #(.data_width(8), .address_width(8)) u_ram (
    .clk     (clk),
    .address (m_addr),
    .data    (m_data),
    .wren    (m_wren),
    .q       (ram_q)
  );

  typedef struct {
    logic       wren;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    check(name, cnt, 256);
  endtask

  task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [7:0] d, output logic [7:0] q);
    bus.cpu_wren    = wr;
    bus.cpu_address = a;
    bus.cpu_data    = d;
    step();
    q = bus.cpu_q;
    bus.cpu_wren = 1'b0;
  endtask

  task automatic load_stream(input int gap_mod, input int dump_at, input int stop_at, input logic [7:0] xv,
                             output int writes, output int gap_writes, output int addr_err, output int dump_beats);
    int   idx, cyc;
    logic v;
    idx = 0; cyc = 0; writes = 0; gap_writes = 0; addr_err = 0; dump_beats = 0;
    while (idx < stop_at && cyc < 1000) begin
      v = 1'b1;
      if (gap_mod != 0) begin
        if ((cyc % gap_mod) == gap_mod - 1) v = 1'b0;
      end
      bus.load_valid = v;
      bus.load_data  = idx[7:0] ^ xv;
      bus.dump_start = (cyc == dump_at);
      #1;
      if (!v && ctl_wren) gap_writes++;
      if (ctl_wren) begin
        writes++;
        if (ctl_addr !== idx[7:0]) addr_err++;
      end
      if (bus.dump_valid) dump_beats++;
      step();
      if (v) idx++;
      cyc++;
    end
    bus.load_valid = 1'b0;
    bus.dump_start = 1'b0;
  endtask

  logic [7:0] q;
  int wr, gw, ae, db;
  int first, beats, data_err, last_err, leak, noncontig, stray;
  logic ended;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h7F, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 8'h12, 8'h5C, 8'h5C};
    vecs[4] = '{1'b0, 8'h12, 8'h00, 8'h5C};
    vecs[5] = '{1'b1, 8'h34, 8'hA5, 8'hA5};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00};
    vecs[7] = '{1'b0, 8'h34, 8'h00, 8'hA5};
    vecs[8] = '{1'b0, 8'h12, 8'h00, 8'h5C};
    vecs[9] = '{1'b0, 8'h35, 8'h00, 8'h00};

    reset_n = 1'b0;
    preload = 1'b1;
    pre_addr = 8'h00; pre_data = 8'hAA;
    bus.cpu_address = 8'h00; bus.cpu_data = 8'h00; bus.cpu_wren = 1'b0;
    bus.load_start = 1'b0; bus.load_data = 8'h00; bus.load_valid = 1'b0;
    bus.dump_start = 1'b0;

    // fill RAM with 0xAA while the controller is held in reset
    for (int i = 0; i < 256; i++) begin
      pre_addr = i[7:0];
      step();
    end
    preload = 1'b0;
    step();
    check("reset_busy", bus.busy, 1);
    check("reset_load_ready", bus.load_ready, 0);
    check("reset_dump_valid", bus.dump_valid, 0);
    check("reset_dump_last", bus.dump_last, 0);

    reset_n = 1'b1;
    wait_clear("clear_cycles");

    // CPU access vectors in IDLE
    for (int i = 0; i < 10; i++) begin
      cpu_op(vecs[i].wren, vecs[i].addr, vecs[i].data, q);
      check($sformatf("cpu_vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("cpu_vec%0d_busy", i), bus.busy, 0);
    end

    // bulk load with a gap every third cycle
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    check("load_ready_first", bus.load_ready, 1);
    check("load_busy", bus.busy, 1);
    load_stream(3, -1, 256, 8'h3C, wr, gw, ae, db);
    check("load_writes", wr, 256);
    check("load_gap_writes", gw, 0);
    check("load_addr_err", ae, 0);
    check("load_busy_after", bus.busy, 0);
    check("load_ready_after", bus.load_ready, 0);
    cpu_op(1'b0, 8'h10, 8'h00, q);
    check("load_readback_10", q, 8'h2C);

    // bulk dump; CPU writes attempted during the dump must be masked
    bus.dump_start = 1'b1;
    first = -1; beats = 0; data_err = 0; last_err = 0; leak = 0; noncontig = 0; ended = 1'b0;
    for (int s = 1; s <= 300; s++) begin
      step();
      if (s == 1) begin
        bus.dump_start = 1'b0;
        bus.cpu_address = 8'h05; bus.cpu_data = 8'hFF; bus.cpu_wren = 1'b1;
      end else if (bus.cpu_wren && ctl_wren) begin
        leak++;
      end
      if (bus.dump_valid) begin
        if (ended) noncontig++;
        if (first < 0) first = s;
        if (bus.dump_data !== (beats[7:0] ^ 8'h3C)) data_err++;
        if (bus.dump_last !== (beats == 255)) last_err++;
        if (bus.dump_last) bus.cpu_wren = 1'b0;
        beats++;
      end else if (first >= 0) begin
        ended = 1'b1;
      end
    end
    bus.cpu_wren = 1'b0;
    check("dump_first_beat", first, 2);
    check("dump_beats", beats, 256);
    check("dump_noncontig", noncontig, 0);
    check("dump_data_err", data_err, 0);
    check("dump_last_err", last_err, 0);
    check("dump_cpu_wr_leak", leak, 0);
    check("dump_busy_after", bus.busy, 0);
    cpu_op(1'b0, 8'h05, 8'h00, q);
    check("dump_masked_05", q, 8'h39);

    // simultaneous starts: load wins, dump_start during LOAD ignored
    bus.load_start = 1'b1;
    bus.dump_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.dump_start = 1'b0;
    check("both_load_ready", bus.load_ready, 1);
    load_stream(0, 10, 256, 8'h00, wr, gw, ae, db);
    check("both_writes", wr, 256);
    check("both_dump_beats", db, 0);
    stray = 0;
    for (int s = 0; s < 10; s++) begin
      if (bus.dump_valid) stray++;
      step();
    end
    check("both_no_dump_after", stray, 0);
    check("both_busy_after", bus.busy, 0);
    cpu_op(1'b0, 8'h80, 8'h00, q);
    check("both_readback_80", q, 8'h80);

    // reset in the middle of a load
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    load_stream(0, -1, 100, 8'h3C, wr, gw, ae, db);
    check("abort_writes", wr, 100);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1);
    check("abort_load_ready", bus.load_ready, 0);
    check("abort_dump_valid", bus.dump_valid, 0);
    check("abort_ram_wren", ctl_wren, 1);
    check("abort_ram_addr", ctl_addr, 0);
    step();
    step();
    reset_n = 1'b1;
    wait_clear("abort_clear_cycles");
    cpu_op(1'b0, 8'd50, 8'h00, q);
    check("abort_readback_50", q, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
